// File: rtl/inst_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues one instruction-bus read
// at a time and uses a one-entry skid buffer so a stalled pipeline never loses data.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BUF
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_redir_pc;
  logic        r_discard;
  logic        r_buf_valid;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;

  logic        w_in_req;
  logic        w_advance;
  logic        w_ack_acc;
  logic        w_ack_drop;
  logic        w_branch;
  logic        w_redirect;
  logic [31:0] w_redir_target;
  logic [31:0] w_pc_inc;
  logic        w_unused_stall;

  // Only the fetch-stage bit of the stall vector matters here.
  assign w_unused_stall = ^stall[5:1];

  assign w_in_req       = (r_state == S_REQ);
  assign w_advance      = ~stall[0];
  assign w_ack_acc      = w_in_req & ibus_ack_i & ~r_discard;
  assign w_ack_drop     = w_in_req & ibus_ack_i & r_discard;
  assign w_branch       = branch_flag_i & w_advance & ~flush;
  assign w_redirect     = flush | w_branch;
  assign w_redir_target = flush ? new_pc : branch_target_addr_i;
  assign w_pc_inc       = r_pc + 32'd4;

  assign ibus_req_o  = w_in_req;
  assign ibus_addr_o = w_in_req ? r_pc : 32'd0;
  assign if_pc       = r_if_pc;
  assign if_inst     = r_if_inst;
  assign stallreq_o  = ~r_buf_valid & ~w_ack_acc & (w_in_req | r_discard);

  // While a read is outstanding r_pc must keep driving the bus, so a redirect
  // that arrives before the ack is parked in r_redir_pc until that ack is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_redir_pc  <= 32'd0;
      r_discard   <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= 32'd0;
      r_buf_inst  <= 32'd0;
      r_if_pc     <= 32'd0;
      r_if_inst   <= 32'd0;
    end else if (w_redirect) begin
      r_buf_valid <= 1'b0;
      r_if_pc     <= 32'd0;
      r_if_inst   <= 32'd0;
      r_state     <= S_REQ;
      if (w_in_req && !ibus_ack_i) begin
        r_discard  <= 1'b1;
        r_redir_pc <= w_redir_target;
      end else begin
        r_discard <= 1'b0;
        r_pc      <= w_redir_target;
      end
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_ack_drop) begin
            r_discard <= 1'b0;
            r_pc      <= r_redir_pc;
          end else if (w_ack_acc) begin
            r_pc <= w_pc_inc;
            if (!w_advance) begin
              r_buf_valid <= 1'b1;
              r_buf_pc    <= r_pc;
              r_buf_inst  <= ibus_rdata_i;
              r_state     <= S_BUF;
            end
          end
        end
        S_BUF: begin
          if (w_advance) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_advance) begin
        if (r_buf_valid) begin
          r_if_pc     <= r_buf_pc;
          r_if_inst   <= r_buf_inst;
          r_buf_valid <= 1'b0;
        end else if (w_ack_acc) begin
          r_if_pc   <= r_pc;
          r_if_inst <= ibus_rdata_i;
        end else begin
          r_if_pc   <= 32'd0;
          r_if_inst <= 32'd0;
        end
      end
    end
  end

endmodule
